// File: rtl/ysyx_24070014_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and hands
// each instruction downstream; redirects from execute discard in-flight work.
module ysyx_24070014_ifu #(
  parameter int                    ADDR_LEN = 32,
  parameter int                    INST_LEN = 32,
  parameter logic [ADDR_LEN-1:0]   INIT_PC  = 32'h80000000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_LEN-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic [ADDR_LEN-1:0] inst_pc_plus_4,
  input  logic                redirect_valid,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  output logic                misaligned_redirect,
  output logic [31:0]         fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t              state, state_n;
  logic [ADDR_LEN-1:0] pc, pc_n;
  logic [INST_LEN-1:0] inst_q, inst_q_n;
  logic [31:0]         cnt_n;
  logic                mis_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= S_IDLE;
      pc                  <= INIT_PC;
      inst_q              <= '0;
      fetch_count         <= '0;
      misaligned_redirect <= 1'b0;
    end else begin
      state               <= state_n;
      pc                  <= pc_n;
      inst_q              <= inst_q_n;
      fetch_count         <= cnt_n;
      misaligned_redirect <= mis_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    inst_q_n = inst_q;
    cnt_n    = fetch_count;
    mis_n    = misaligned_redirect;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_n = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_n = S_REQ;
          end else begin
            state_n  = S_HOLD;
            inst_q_n = imem_resp_data;
          end
        end else if (redirect_valid) begin
          state_n = S_DROP;
        end
      end
      S_HOLD: begin
        // a handshake coinciding with a redirect still counts as consumed
        if (inst_ready) begin
          cnt_n   = fetch_count + 32'd1;
          pc_n    = pc + ADDR_LEN'(4);
          state_n = S_REQ;
        end
        if (redirect_valid) state_n = S_REQ;
      end
      S_DROP: begin
        // the stale response closes the outstanding request even if a new
        // redirect lands in the same cycle; only the pc is updated then
        if (imem_resp_valid) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
    if (redirect_valid) begin
      pc_n = {redirect_pc[ADDR_LEN-1:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) mis_n = 1'b1;
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = pc;
  assign inst_pc_plus_4 = pc + ADDR_LEN'(4);

endmodule

// File: tb/tb_ysyx_24070014_ifu.sv
// Bench for ysyx_24070014_ifu: directed scenarios followed by random traffic, all
// checked against a transaction-level model (expected pc, count, memory contents).
module tb_ysyx_24070014_ifu;
  localparam logic [31:0] INIT_PC = 32'h80000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, inst_pc_plus_4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned_redirect;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  ysyx_24070014_ifu dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_plus_4(inst_pc_plus_4), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .misaligned_redirect(misaligned_redirect),
    .fetch_count(fetch_count)
  );

  int n_cmp = 0, n_err = 0, cyc_n = 0;
  // stimulus knobs
  int rdy_pct, irdy_pct, redir_pct, spur_pct, dly_min, dly_max;
  bit mem_nop, force_redir, stale_override;
  logic [31:0] force_addr;
  // reference model
  logic [31:0] exp_pc, exp_cnt, m_data;
  bit   exp_mis, outst, last_req_fire, saw_bad, prev_vld, prev_resp, prev_redir;
  int   m_dly, n_req, idle_cnt, last_rv_cyc;
  // scratch for directed steps
  int          req_cyc[$];
  logic [31:0] req_adr[$];
  logic [31:0] si, sp, sc, cnt0;
  int          t, n0;

  // odd multiplier keeps distinct addresses mapping to distinct words
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (mem_nop) return 32'h00000013;
    return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  function automatic logic [31:0] rand_target();
    case ($urandom_range(3))
      0:       return INIT_PC + {20'd0, 10'($urandom_range(1023)), 2'b00};
      1:       return INIT_PC + 32'($urandom_range(4095));
      2:       return 32'hFFFFFFF0 + 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, INIT_PC);
    chk({tag, "_pc_plus_4"}, inst_pc_plus_4, INIT_PC + 32'd4);
    chk({tag, "_count"}, fetch_count, 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned_redirect), 32'd0);
  endtask

  task automatic model_reset();
    exp_pc = INIT_PC; exp_cnt = 0; exp_mis = 0; outst = 0; m_dly = 0;
    prev_vld = 0; prev_resp = 0; prev_redir = 0; idle_cnt = 0; last_req_fire = 0;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cyc();
    logic [31:0] raddr;
    bit redir, rdy, irdy, rv, fire, hs;
    chk("req_addr", imem_req_addr, exp_pc);
    chk("inst_pc", inst_pc, exp_pc);
    chk("inst_pc_plus_4", inst_pc_plus_4, exp_pc + 32'd4);
    chk("fetch_count", fetch_count, exp_cnt);
    chk("misaligned", 32'(misaligned_redirect), 32'(exp_mis));
    chk("req_and_inst", 32'(imem_req_valid & inst_valid), 32'd0);
    chk("progress", 32'(idle_cnt > 200), 32'd0);
    if (imem_req_valid) chk("one_outstanding", 32'(outst), 32'd0);
    if (inst_valid) chk("inst_data", inst, mem(exp_pc));
    if (inst_valid && !prev_vld) chk("inst_valid_rise", 32'(prev_resp & ~prev_redir), 32'd1);
    if (inst_valid && inst == 32'hDEADBEEF) saw_bad = 1;

    rdy   = ($urandom_range(99) < rdy_pct);
    irdy  = ($urandom_range(99) < irdy_pct);
    redir = force_redir || ($urandom_range(99) < redir_pct);
    raddr = force_redir ? force_addr : rand_target();
    force_redir = 0;
    rv = outst && (m_dly == 0);
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = redir ? raddr : $urandom;
    if (rv) begin
      imem_resp_valid = 1; imem_resp_data = m_data; last_rv_cyc = cyc_n;
    end else if (!outst && $urandom_range(99) < spur_pct) begin
      imem_resp_valid = 1; imem_resp_data = 32'hBAD0BAD0;
    end else begin
      imem_resp_valid = 0; imem_resp_data = $urandom;
    end

    fire = imem_req_valid && rdy;
    hs   = inst_valid && irdy;
    if (rv) outst = 0;
    else if (outst) m_dly--;
    if (fire) begin
      outst  = 1;
      m_dly  = int'($urandom_range(dly_max, dly_min));
      m_data = stale_override ? 32'hDEADBEEF : mem(imem_req_addr);
      stale_override = 0;
      n_req++;
    end
    last_req_fire = fire;
    if (hs) exp_cnt++;
    if (redir) begin
      exp_pc = raddr & ~32'd3;
      if (raddr[1:0] != 2'b00) exp_mis = 1;
    end else if (hs) begin
      exp_pc = exp_pc + 32'd4;
    end
    idle_cnt   = (hs || redir) ? 0 : idle_cnt + 1;
    prev_vld   = inst_valid;
    prev_resp  = rv;
    prev_redir = redir;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    rdy_pct = 100; irdy_pct = 100; redir_pct = 0; spur_pct = 0; dly_min = 0; dly_max = 0;
    mem_nop = 1; force_redir = 0; stale_override = 0; force_addr = 0;
    n_req = 0; saw_bad = 0; last_rv_cyc = 0;
    model_reset();
    #3;
    chk_reset("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // straight-line fetch, ready memory, zero-wait responses
    repeat (10) begin
      if (imem_req_valid) begin req_cyc.push_back(cyc_n); req_adr.push_back(imem_req_addr); end
      cyc();
    end
    chk("t1_nreq", 32'(req_cyc.size()), 32'd3);
    if (req_cyc.size() >= 3) begin
      chk("t1_first_cycle", 32'(req_cyc[0]), 32'd1);
      chk("t1_addr0", req_adr[0], 32'h80000000);
      chk("t1_addr1", req_adr[1], 32'h80000004);
      chk("t1_addr2", req_adr[2], 32'h80000008);
      chk("t1_gap1", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
      chk("t1_gap2", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
    end
    chk("t1_count", fetch_count, 32'd3);

    // request stalled 4 cycles, response 5 cycles late
    mem_nop = 0; rdy_pct = 0; irdy_pct = 0; dly_min = 5; dly_max = 5;
    n0 = n_req;
    repeat (4) begin chk("t2_addr", imem_req_addr, 32'h8000000C); cyc(); end
    rdy_pct = 100;
    t = 0;
    while (!inst_valid && t < 20) begin cyc(); t++; end
    chk("t2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t2_nreq", 32'(n_req - n0), 32'd1);
    chk("t2_valid_lag", 32'(cyc_n - last_rv_cyc), 32'd1);

    // downstream backpressure in HOLD
    si = inst; sp = inst_pc; sc = fetch_count;
    repeat (6) begin
      cyc();
      chk("t3_inst", inst, si);
      chk("t3_inst_pc", inst_pc, sp);
      chk("t3_count", fetch_count, sc);
      chk("t3_no_req", 32'(imem_req_valid), 32'd0);
    end
    irdy_pct = 100;
    cyc();
    chk("t3_next_req", 32'(imem_req_valid), 32'd1);
    chk("t3_next_addr", imem_req_addr, sp + 32'd4);

    // redirect while WAIT, stale DEADBEEF arrives two cycles later
    irdy_pct = 0; dly_min = 2; dly_max = 2; stale_override = 1;
    t = 0;
    do begin cyc(); t++; end while (!last_req_fire && t < 10);
    chk("t4_fired", 32'(last_req_fire), 32'd1);
    cnt0 = fetch_count; saw_bad = 0;
    force_redir = 1; force_addr = 32'h80001000;
    cyc();
    t = 0;
    while (!imem_req_valid && t < 10) begin cyc(); t++; end
    chk("t4_latency", 32'(t), 32'd2);
    chk("t4_addr", imem_req_addr, 32'h80001000);
    chk("t4_count", fetch_count, cnt0);
    dly_min = 0; dly_max = 0;
    t = 0;
    while (!inst_valid && t < 10) begin cyc(); t++; end
    chk("t4_stale_hidden", 32'(saw_bad), 32'd0);

    // misaligned redirect together with a HOLD handshake
    cnt0 = fetch_count;
    force_redir = 1; force_addr = 32'h80000102; irdy_pct = 100;
    cyc();
    chk("t5_count", fetch_count, cnt0 + 32'd1);
    chk("t5_req", 32'(imem_req_valid), 32'd1);
    chk("t5_addr", imem_req_addr, 32'h80000100);
    chk("t5_misaligned", 32'(misaligned_redirect), 32'd1);

    // pc+4 wrap at the top of the address space
    irdy_pct = 0;
    force_redir = 1; force_addr = 32'hFFFFFFFC;
    cyc();
    t = 0;
    while (!inst_valid && t < 20) begin cyc(); t++; end
    chk("t7_inst_pc", inst_pc, 32'hFFFFFFFC);
    chk("t7_plus_4", inst_pc_plus_4, 32'h00000000);
    irdy_pct = 100;
    cyc();
    chk("t7_wrap_addr", imem_req_addr, 32'h00000000);

    // asynchronous reset in WAIT with a response arriving during reset
    dly_min = 3; dly_max = 3;
    t = 0;
    do begin cyc(); t++; end while (!last_req_fire && t < 10);
    reset = 1;
    #1;
    chk_reset("t6_async");
    model_reset();
    imem_resp_valid = 1; imem_resp_data = 32'hBAD0BAD0;
    @(posedge clk); #1;
    imem_resp_valid = 0;
    @(posedge clk); #1;
    chk_reset("t6_held");
    reset = 0;
    spur_pct = 100;
    cyc();
    spur_pct = 0; dly_min = 0; dly_max = 0;
    t = 0;
    while (!imem_req_valid && t < 5) begin cyc(); t++; end
    chk("t6_first_addr", imem_req_addr, INIT_PC);
    t = 0;
    while (!inst_valid && t < 10) begin cyc(); t++; end
    chk("t6_inst", inst, mem(INIT_PC));

    // randomized traffic
    repeat (40) begin
      rdy_pct   = int'($urandom_range(100, 20));
      irdy_pct  = int'($urandom_range(100, 20));
      redir_pct = int'($urandom_range(10));
      spur_pct  = int'($urandom_range(30));
      dly_min   = int'($urandom_range(2));
      dly_max   = dly_min + int'($urandom_range(4));
      repeat (50) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
